// File: rtl/multi_blink.sv
// Multi-channel LED blinker: one shared free-running prescaler drives NCH
// independently configured channels (off / on / blink / counted burst).
module multi_blink #(
    parameter int NCH   = 4,
    parameter int CBITS = 23,
    parameter int DIVW  = 4,
    parameter int BW    = 8,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [DIVW-1:0]  cfg_div,
    input  logic [BW-1:0]    cfg_burst,
    output logic             tick,
    output logic [NCH-1:0]   led,
    output logic [NCH-1:0]   done
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_t;

    logic [CBITS-1:0] cnt_r;
    logic             tick_r;
    logic             ready_r;
    logic             accept_s;

    mode_t            mode_r [NCH];
    mode_t            mode_s [NCH];
    logic [DIVW-1:0]  div_r  [NCH];
    logic [DIVW-1:0]  div_s  [NCH];
    logic [DIVW-1:0]  sub_r  [NCH];
    logic [DIVW-1:0]  sub_s  [NCH];
    logic [BW-1:0]    rem_r  [NCH];
    logic [BW-1:0]    rem_s  [NCH];
    logic [NCH-1:0]   led_r, led_s;
    logic [NCH-1:0]   done_r, done_s;

    assign accept_s  = cfg_valid & ready_r;
    assign cfg_ready = ready_r;
    assign tick      = tick_r;
    assign led       = led_r;
    assign done      = done_r;

    // Per-channel next state; an accepted config takes priority over a coincident tick.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            mode_s[i] = mode_r[i];
            div_s[i]  = div_r[i];
            sub_s[i]  = sub_r[i];
            rem_s[i]  = rem_r[i];
            led_s[i]  = led_r[i];
            done_s[i] = 1'b0;
            if (accept_s && (int'(cfg_ch) == i)) begin
                div_s[i] = cfg_div;
                rem_s[i] = cfg_burst;
                sub_s[i] = {DIVW{1'b0}};
                case (cfg_mode)
                    MODE_OFF: begin
                        mode_s[i] = MODE_OFF;
                        led_s[i]  = 1'b0;
                    end
                    MODE_ON: begin
                        mode_s[i] = MODE_ON;
                        led_s[i]  = 1'b1;
                    end
                    MODE_BLINK: begin
                        mode_s[i] = MODE_BLINK;
                        led_s[i]  = 1'b1;
                    end
                    MODE_BURST: begin
                        // A zero-length burst finishes immediately.
                        if (cfg_burst == {BW{1'b0}}) begin
                            mode_s[i] = MODE_OFF;
                            led_s[i]  = 1'b0;
                            done_s[i] = 1'b1;
                        end else begin
                            mode_s[i] = MODE_BURST;
                            led_s[i]  = 1'b1;
                        end
                    end
                    default: begin
                        mode_s[i] = MODE_OFF;
                        led_s[i]  = 1'b0;
                    end
                endcase
            end else if (tick_r && ((mode_r[i] == MODE_BLINK) || (mode_r[i] == MODE_BURST))) begin
                if (sub_r[i] == div_r[i]) begin
                    sub_s[i] = {DIVW{1'b0}};
                    led_s[i] = ~led_r[i];
                    if ((mode_r[i] == MODE_BURST) && led_r[i]) begin
                        rem_s[i] = rem_r[i] - BW'(1);
                        if (rem_r[i] == BW'(1)) begin
                            mode_s[i] = MODE_OFF;
                            led_s[i]  = 1'b0;
                            done_s[i] = 1'b1;
                        end else begin
                        end
                    end else begin
                    end
                end else begin
                    sub_s[i] = sub_r[i] + DIVW'(1);
                end
            end else begin
            end
        end
    end

    // Prescaler, tick strobe and config handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= {CBITS{1'b0}};
            tick_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            cnt_r   <= cnt_r + CBITS'(1);
            tick_r  <= (cnt_r == {CBITS{1'b0}});
            ready_r <= ~accept_s;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                mode_r[i] <= MODE_OFF;
                div_r[i]  <= {DIVW{1'b0}};
                sub_r[i]  <= {DIVW{1'b0}};
                rem_r[i]  <= {BW{1'b0}};
            end
            led_r  <= {NCH{1'b0}};
            done_r <= {NCH{1'b0}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                mode_r[i] <= mode_s[i];
                div_r[i]  <= div_s[i];
                sub_r[i]  <= sub_s[i];
                rem_r[i]  <= rem_s[i];
            end
            led_r  <= led_s;
            done_r <= done_s;
        end
    end

endmodule

// File: tb/tb_multi_blink.sv
// Directed bench for multi_blink with NCH=5 (so cfg_ch=5 is out of range) and CBITS=3.
module tb_multi_blink;

    localparam int NCH = 5;
    localparam int CHW = 3;

    logic           clk;
    logic           rst;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [1:0]     cfg_mode;
    logic [3:0]     cfg_div;
    logic [7:0]     cfg_burst;
    logic           tick;
    logic [NCH-1:0] led;
    logic [NCH-1:0] done;

    int n_checks = 0;
    int n_fail   = 0;

    multi_blink #(.NCH(NCH), .CBITS(3), .DIVW(4), .BW(8)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_div(cfg_div), .cfg_burst(cfg_burst),
        .tick(tick), .led(led), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           v;
        logic [CHW-1:0] ch;
        logic [1:0]     mode;
        logic [3:0]     div;
        logic           rdy;
        logic           tk;
        logic [NCH-1:0] led;
    } vec_t;

    vec_t vt [40];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CHW-1:0] ch, input logic [1:0] mode,
                         input logic [3:0] div, input logic [7:0] burst);
        cfg_valid = v;
        cfg_ch    = ch;
        cfg_mode  = mode;
        cfg_div   = div;
        cfg_burst = burst;
    endtask

    task automatic do_reset();
        drive(1'b0, 3'd0, 2'd0, 4'd0, 8'd0);
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
    endtask

    // Leaves the bench just after an edge where tick was seen high, so the next edge is a tick edge.
    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = (tick === 1'b1);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wait_tick: got no tick expected one within 20 cycles");
        end
    endtask

    initial begin
        logic exp_l1, exp_l2, exp_l3, exp_l0, seen0;

        rst = 1'b0;
        drive(1'b0, 3'd0, 2'd0, 4'd0, 8'd0);

        // Reset state
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_tick", 32'(tick), 32'd0);
            check("rst_led", 32'(led), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_ready", 32'(cfg_ready), 32'd1);
        end
        rst = 1'b1;

        // Tick after 1st edge, then every 8 cycles
        for (int k = 1; k <= 17; k++) begin
            step();
            check("tick_period", 32'(tick), ((k % 8) == 1) ? 32'd1 : 32'd0);
            check("tick_led", 32'(led), 32'd0);
        end

        // Table: BLINK ch1 div=1, back-to-back handshakes, out-of-range channel
        for (int j = 1; j <= 40; j++) begin
            vt[j-1].v    = 1'b0;
            vt[j-1].ch   = 3'd0;
            vt[j-1].mode = 2'd0;
            vt[j-1].div  = 4'd0;
            vt[j-1].rdy  = 1'b1;
            vt[j-1].tk   = ((j % 8) == 0);
            vt[j-1].led  = ((j < 17) || (j >= 33)) ? 5'b11010 : 5'b11000;
        end
        vt[0] = '{1'b1, 3'd1, 2'd2, 4'd1, 1'b0, 1'b0, 5'b00010};
        vt[1] = '{1'b1, 3'd3, 2'd1, 4'd0, 1'b1, 1'b0, 5'b00010};
        vt[2] = '{1'b1, 3'd3, 2'd1, 4'd0, 1'b0, 1'b0, 5'b01010};
        vt[3] = '{1'b1, 3'd4, 2'd1, 4'd0, 1'b1, 1'b0, 5'b01010};
        vt[4] = '{1'b1, 3'd4, 2'd1, 4'd0, 1'b0, 1'b0, 5'b11010};
        vt[5] = '{1'b1, 3'd5, 2'd1, 4'd0, 1'b1, 1'b0, 5'b11010};
        vt[6] = '{1'b1, 3'd5, 2'd1, 4'd0, 1'b0, 1'b0, 5'b11010};

        wait_tick();
        for (int j = 0; j < 40; j++) begin
            drive(vt[j].v, vt[j].ch, vt[j].mode, vt[j].div, 8'd0);
            step();
            check("tbl_ready", 32'(cfg_ready), 32'(vt[j].rdy));
            check("tbl_tick", 32'(tick), 32'(vt[j].tk));
            check("tbl_led", 32'(led), 32'(vt[j].led));
            check("tbl_done", 32'(done), 32'd0);
        end
        drive(1'b0, 3'd0, 2'd0, 4'd0, 8'd0);

        // Rewrite ch1 BLINK -> ON during its low phase
        seen0 = 1'b0;
        for (int i = 0; i < 40 && !seen0; i++) begin
            step();
            seen0 = (led[1] === 1'b0);
        end
        check("rewrite_low_seen", 32'(seen0), 32'd1);
        drive(1'b1, 3'd1, 2'd1, 4'd0, 8'd0);
        step();
        drive(1'b0, 3'd0, 2'd0, 4'd0, 8'd0);
        check("rewrite_on", 32'(led), 32'h1a);
        for (int i = 0; i < 40; i++) begin
            step();
            check("rewrite_hold", 32'(led[1]), 32'd1);
        end

        // BURST ch0 div=0 burst=3, accepted on a tick edge
        do_reset();
        wait_tick();
        drive(1'b1, 3'd0, 2'd3, 4'd0, 8'd3);
        for (int j = 1; j <= 60; j++) begin
            step();
            drive(1'b0, 3'd0, 2'd0, 4'd0, 8'd0);
            exp_l0 = ((j >= 1) && (j <= 8)) || ((j >= 17) && (j <= 24)) || ((j >= 33) && (j <= 40));
            check("burst_led", 32'(led), 32'(exp_l0));
            check("burst_done", 32'(done), (j == 41) ? 32'd1 : 32'd0);
        end

        // BURST with count 0: done next cycle, no pulse
        drive(1'b1, 3'd0, 2'd3, 4'd2, 8'd0);
        step();
        drive(1'b0, 3'd0, 2'd0, 4'd0, 8'd0);
        check("burst0_led", 32'(led), 32'd0);
        check("burst0_done", 32'(done), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step();
            check("burst0_quiet_led", 32'(led), 32'd0);
            check("burst0_quiet_done", 32'(done), 32'd0);
        end

        // Collision: ch2 written on a tick edge while ch3 toggles on that same tick
        do_reset();
        wait_tick();
        for (int j = 1; j <= 32; j++) begin
            if (j == 1) begin
                drive(1'b1, 3'd3, 2'd2, 4'd0, 8'd0);
            end else if (j == 9) begin
                drive(1'b1, 3'd2, 2'd2, 4'd1, 8'd0);
            end else begin
                drive(1'b0, 3'd0, 2'd0, 4'd0, 8'd0);
            end
            step();
            exp_l3 = ((((j - 1) / 8) % 2) == 0);
            exp_l2 = (j >= 9) && (j < 25);
            check("coll_led", 32'(led), 32'({1'b0, exp_l3, exp_l2, 2'b00}));
            if (j == 8) begin
                check("coll_tick", 32'(tick), 32'd1);
            end else begin
            end
        end
        drive(1'b0, 3'd0, 2'd0, 4'd0, 8'd0);

        // Reset during the second burst pulse
        do_reset();
        wait_tick();
        drive(1'b1, 3'd0, 2'd3, 4'd0, 8'd3);
        for (int j = 1; j <= 20; j++) begin
            step();
            drive(1'b0, 3'd0, 2'd0, 4'd0, 8'd0);
        end
        check("midrst_pre_led", 32'(led), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_led", 32'(led), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_tick", 32'(tick), 32'd0);
        check("midrst_ready", 32'(cfg_ready), 32'd1);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            check("postrst_led", 32'(led), 32'd0);
            check("postrst_done", 32'(done), 32'd0);
        end

        exp_l1 = 1'b0;
        if (exp_l1) begin
        end else begin
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_blink.md
# multi_blink

Multi-channel, parametrised LED blinker: one free-running prescaler shared by NCH independent output channels. Each channel is set at run time through a valid/ready config port to one of four modes: off, on, continuous blink, or counted burst. A channel in burst mode reports completion with a one-cycle done pulse. The block sits between the system control logic and the board LED pins. It provides the single-clock, slow-tick indicator function for the whole design.

## Interface
- NCH, default 4: number of LED channels (1..16).
- CBITS, default 23: prescaler width; tick period is 2^CBITS cycles.
- DIVW, default 4: per-channel divider width; half-period is (div+1) ticks.
- BW, default 8: burst-count width.
- CHW, derived as max(1, clog2(NCH)): channel-select width.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  block can accept a config this cycle.
- cfg_ch  input  CHW  target channel.
- cfg_mode  input  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 BURST.
- cfg_div  input  DIVW  half-period in ticks, minus 1.
- cfg_burst  input  BW  number of on/off periods for BURST.
- tick  output  1  one-cycle strobe at each prescaler wrap.
- led  output  NCH  per-channel LED drive, registered.
- done  output  NCH  one-cycle pulse when a BURST completes.

## Operation
- Prescaler cnt[CBITS-1:0] increments every cycle and wraps modulo 2^CBITS.
- tick is registered as (cnt == 0).
- A config is accepted when cfg_valid & cfg_ready at a clock edge. cfg_ready is 0 for exactly the cycle after an accept and 1 otherwise.
- A config with cfg_ch >= NCH is accepted (handshake completes) and ignored.
- On accept, the target channel loads its mode, div and burst count, and clears its phase counter sub.
  - OFF: led = 0.
  - ON: led = 1.
  - BLINK / BURST: led = 1 from the next cycle.
  - Any pending done on that channel is cancelled.
- Per-channel state: mode[1:0], div[DIVW-1:0], sub[DIVW-1:0], rem[BW-1:0], led bit.
- On each tick, for each channel in BLINK or BURST:
  - If sub == div: sub <= 0 and led toggles.
  - Otherwise: sub <= sub + 1.
- BURST counting:
  - Each 1->0 toggle decrements rem.
  - When the toggle that takes rem from 1 to 0 occurs, the channel goes to OFF (led = 0) and done[ch] pulses for one cycle.
- BURST with cfg_burst = 0: the channel goes to OFF on accept, and done[ch] pulses in the cycle after the accept edge.
- OFF and ON channels ignore tick.
- An accept coinciding with a tick on the same channel: the config wins, the tick is discarded for that channel, and sub = 0. Other channels process the tick normally.
- Channels are fully independent. A config to one channel never disturbs another channel's led, sub or rem.
- Reset (rst = 0, asynchronous, any time, including mid-burst) forces:
  - cnt = 0, tick = 0, led = 0, done = 0, cfg_ready = 1.
  - All modes = OFF; sub, rem and div = 0.
  - Nothing resumes after reset release.

## Timing
- The first tick is high in the cycle after the first rising edge following reset release. Subsequent ticks occur every 2^CBITS cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Config-to-led latency: 1 cycle.
- Maximum config rate: one accept per 2 cycles.
- BLINK led period = 2*(div+1) ticks = 2*(div+1)*2^CBITS cycles, 50% duty. The first high phase lasts from accept until the (div+1)th tick after accept.
- BURST total high-plus-low time = cfg_burst * 2*(div+1) ticks. done is in the cycle after the final 1->0 toggle edge.
- Counter arithmetic is modulo 2^width. div = 2^DIVW-1 and burst = 2^BW-1 are legal, with no overflow.

## Test plan
- Reset and tick, CBITS=3: hold rst=0 for 3 cycles, release.
  - All outputs must be 0 during reset, with cfg_ready=1.
  - tick must pulse 1 cycle after release, then every 8 cycles; led = 0.
- BLINK, CBITS=3: write ch1 mode=2, div=1.
  - led[1] = 1 from the next cycle and toggles on every 2nd tick (16-cycle half-period).
  - Other led bits stay 0.
- BURST, CBITS=3: write ch0 mode=3, div=0, burst=3.
  - Exactly 3 high pulses of 8 cycles each.
  - done[0] pulses once, one cycle after the 3rd falling edge; ch0 is then OFF. burst=0 gives done in the next cycle and no pulse.
- Handshake and collision:
  - Back-to-back cfg_valid: cfg_ready drops for 1 cycle after each accept, so 2 writes take 4 cycles.
  - A write to ch2 on a tick cycle restarts ch2 with sub=0, while ch3 toggles normally.
  - cfg_ch=NCH is accepted with no state change.
- Reset mid-burst: assert rst during the 2nd burst pulse.
  - led and done clear immediately.
  - After release, ch0 stays OFF and no done is produced.
- Rewrite: switch ch1 from BLINK to ON mid-period; led[1] = 1 permanently from the next cycle.
